peripheral_wb_memory_responder: RTL and testbench

- Wishbone B3 slave memory responder; the target-side counterpart of the Wishbone BFM transactor (initiator) in the peripheral benches.
- Serves classic single cycles and registered-feedback bursts (constant, linear, wrap-4/8/16) with a programmable initial wait-state count.
- Flags out-of-range accesses with an error termination.
- Serves as a bus-level target for transactor self-checks and as a scratch RAM behind peripheral interconnects.

---
 rtl/peripheral_wb_memory_responder.sv | 171 +++++++++++++++++
 tb/tb_peripheral_wb_memory_responder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_wb_memory_responder.sv
// Wishbone B3 slave scratch RAM: classic and registered-feedback bursts,
// programmable initial wait states, error termination outside the mapped window.
module peripheral_wb_memory_responder #(
  parameter int unsigned              WB_ADDR_WIDTH = 32,
  parameter int unsigned              WB_DATA_WIDTH = 32,
  parameter int unsigned              MEM_WORDS     = 1024,
  parameter logic [WB_ADDR_WIDTH-1:0] BASE_ADDR     = '0,
  parameter int unsigned              WAIT_STATES   = 0
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic [WB_ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [WB_DATA_WIDTH-1:0] wb_dat_i,
  input  logic [3:0]               wb_sel_i,
  input  logic                     wb_we_i,
  input  logic                     wb_cyc_i,
  input  logic                     wb_stb_i,
  input  logic [2:0]               wb_cti_i,
  input  logic [1:0]               wb_bte_i,
  output logic [WB_DATA_WIDTH-1:0] wb_dat_o,
  output logic                     wb_ack_o,
  output logic                     wb_err_o,
  output logic                     busy_o,
  output logic [15:0]              ack_cnt_o
);

  // state | meaning
  // IDLE  | no cycle in progress, waiting for cyc&stb
  // WAIT  | counting initial wait states of the first beat
  // RESP  | ack or err registered for the current beat
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int unsigned IW = $clog2(MEM_WORDS);
  localparam logic [WB_ADDR_WIDTH-1:0] MEM_BYTES = WB_ADDR_WIDTH'(MEM_WORDS * 4);

  state_t                   state;
  logic [IW-1:0]            idx;
  logic                     in_rng;
  logic [1:0]               bte_q;
  logic [3:0]               wait_cnt;
  logic [WB_DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic [WB_ADDR_WIDTH-1:0] adr_off;
  logic                     adr_in_range;
  logic [IW-1:0]            adr_idx;
  logic                     ack_beat;
  logic                     wr_en;
  logic                     burst_go;
  logic [WB_DATA_WIDTH-1:0] wr_word;
  logic [WB_DATA_WIDTH-1:0] next_rd;
  logic [IW:0]              lin_next;
  logic [IW-1:0]            wrap_mask;
  logic [IW-1:0]            next_idx;
  logic                     next_ok;

  function automatic logic [WB_DATA_WIDTH-1:0] merge_lanes(
    input logic [WB_DATA_WIDTH-1:0] old_w,
    input logic [WB_DATA_WIDTH-1:0] new_w,
    input logic [3:0]               sel
  );
    logic [WB_DATA_WIDTH-1:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++)
      if (sel[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  assign adr_off      = wb_adr_i - BASE_ADDR;
  assign adr_in_range = (wb_adr_i >= BASE_ADDR) && (adr_off < MEM_BYTES);
  assign adr_idx      = adr_off[IW+1:2];

  assign ack_beat = (state == RESP) && wb_cyc_i && wb_stb_i && wb_ack_o;
  assign wr_en    = ack_beat && wb_we_i;
  assign burst_go = ack_beat && ((wb_cti_i == 3'b001) || (wb_cti_i == 3'b010));
  assign wr_word  = merge_lanes(mem[idx], wb_dat_i, wb_sel_i);
  assign lin_next = {1'b0, idx} + (IW+1)'(1);

  always_comb begin
    wrap_mask = '0;
    case (bte_q)
      2'b01:   wrap_mask = IW'(3);
      2'b10:   wrap_mask = IW'(7);
      2'b11:   wrap_mask = IW'(15);
      default: wrap_mask = '0;
    endcase
  end

  // A linear step past the last word is an error beat; wraps stay in their block.
  always_comb begin
    next_idx = idx;
    next_ok  = 1'b1;
    if (wb_cti_i == 3'b010) begin
      if (bte_q == 2'b00) begin
        next_idx = lin_next[IW-1:0];
        next_ok  = !lin_next[IW];
      end else begin
        next_idx = (idx & ~wrap_mask) | (lin_next[IW-1:0] & wrap_mask);
      end
    end
  end

  // Prefetch for the next beat, forwarding a write landing on the same word.
  assign next_rd = (wr_en && (next_idx == idx)) ? wr_word : mem[next_idx];

  always_ff @(posedge wb_clk_i)
    if (wr_en) mem[idx] <= wr_word;

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state     <= IDLE;
      idx       <= '0;
      in_rng    <= 1'b0;
      bte_q     <= 2'b00;
      wait_cnt  <= '0;
      wb_ack_o  <= 1'b0;
      wb_err_o  <= 1'b0;
      wb_dat_o  <= '0;
      ack_cnt_o <= '0;
    end else begin
      if (ack_beat) ack_cnt_o <= ack_cnt_o + 16'd1;
      case (state)
        IDLE: begin
          wb_ack_o <= 1'b0;
          wb_err_o <= 1'b0;
          if (wb_cyc_i && wb_stb_i) begin
            idx    <= adr_idx;
            in_rng <= adr_in_range;
            bte_q  <= wb_bte_i;
            if (WAIT_STATES == 0) begin
              state    <= RESP;
              wb_ack_o <= adr_in_range;
              wb_err_o <= !adr_in_range;
              wb_dat_o <= adr_in_range ? mem[adr_idx] : '0;
            end else begin
              state    <= WAIT;
              wait_cnt <= 4'(WAIT_STATES - 1);
            end
          end
        end
        WAIT: begin
          if (!(wb_cyc_i && wb_stb_i)) begin
            state <= IDLE;
          end else if (wait_cnt == 4'd0) begin
            state    <= RESP;
            wb_ack_o <= in_rng;
            wb_err_o <= !in_rng;
            wb_dat_o <= in_rng ? mem[idx] : '0;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        RESP: begin
          state    <= IDLE;
          wb_ack_o <= 1'b0;
          wb_err_o <= 1'b0;
          if (burst_go) begin
            state    <= RESP;
            idx      <= next_idx;
            wb_ack_o <= next_ok;
            wb_err_o <= !next_ok;
            wb_dat_o <= next_ok ? next_rd : '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_peripheral_wb_memory_responder.sv
// Bench for peripheral_wb_memory_responder: transaction-level memory model with a
// per-cycle compare process, plus literal expectations for the listed scenarios.
module tb_peripheral_wb_memory_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] adr = '0, wdat = '0;
  logic [3:0]  sel = '0;
  logic        we = 1'b0, cyc = 1'b0, stb = 1'b0, cyc2 = 1'b0, stb2 = 1'b0;
  logic [2:0]  cti = '0;
  logic [1:0]  bte = '0;
  logic [31:0] dat0, dat1;
  logic        ack0, err0, busy0, ack1, err1, busy1;
  logic [15:0] cnt0, cnt1;

  always #5 clk = ~clk;

  peripheral_wb_memory_responder #(.MEM_WORDS(256), .WAIT_STATES(0)) u0 (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_cti_i(cti), .wb_bte_i(bte),
    .wb_dat_o(dat0), .wb_ack_o(ack0), .wb_err_o(err0), .busy_o(busy0), .ack_cnt_o(cnt0));

  peripheral_wb_memory_responder #(.MEM_WORDS(256), .WAIT_STATES(3)) u1 (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc2), .wb_stb_i(stb2), .wb_cti_i(cti), .wb_bte_i(bte),
    .wb_dat_o(dat1), .wb_ack_o(ack1), .wb_err_o(err1), .busy_o(busy1), .ack_cnt_o(cnt1));

  int          n_checks = 0, n_errors = 0;
  logic [31:0] model_mem [256];
  int unsigned model_cnt = 0;
  logic        exp_on = 1'b0, exp_ack = 1'b0, exp_err = 1'b0, exp_dat_chk = 1'b0;
  logic [31:0] exp_dat = '0;
  logic [31:0] rd_cap [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lane_merge(input logic [31:0] o, input logic [31:0] n,
                                             input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (o & ~m) | (n & m);
  endfunction

  always @(negedge clk) begin
    check("ack_err_excl", 32'(ack0 & err0), 32'd0);
    if (exp_on) begin
      check("ack", 32'(ack0), 32'(exp_ack));
      check("err", 32'(err0), 32'(exp_err));
      check("ack_cnt", 32'(cnt0), 32'(model_cnt[15:0]));
      if (exp_dat_chk) check("rdata", dat0, exp_dat);
      if (ack0 && !we) rd_cap.push_back(dat0);
    end
  end

  // Master on u0: beat k carries data d0 + k*dstep; kind 000 single, 001 constant, 010 incrementing.
  task automatic xfer(input logic [31:0] a0, input logic w, input int n, input logic [2:0] kind,
                      input logic [1:0] b, input logic [3:0] s, input logic [31:0] d0,
                      input logic [31:0] dstep);
    int unsigned len, i0, ib;
    logic        ok;
    len = (b == 2'b01) ? 4 : (b == 2'b10) ? 8 : (b == 2'b11) ? 16 : 0;
    i0  = a0 >> 2;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; sel = s; bte = b;
    exp_on = 1'b1; exp_ack = 1'b0; exp_err = 1'b0; exp_dat_chk = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (kind == 3'b001 || n == 1) ib = i0;
      else if (len == 0) ib = i0 + k;
      else ib = (i0 / len) * len + (i0 + k) % len;
      ok   = (ib < 256);
      adr  = (k == 0) ? a0 : ib << 2;
      cti  = (n == 1) ? 3'b000 : (k == n - 1) ? 3'b111 : kind;
      wdat = d0 + k * dstep;
      if (k == 0) begin @(posedge clk); #1; end
      exp_ack = ok; exp_err = !ok; exp_dat_chk = !w || !ok;
      exp_dat = '0;
      if (ok) exp_dat = model_mem[ib];
      @(posedge clk);
      if (ok) begin
        if (w) model_mem[ib] = lane_merge(model_mem[ib], wdat, s);
        model_cnt++;
      end
      #1;
      if (!ok) break;
    end
    cyc = 1'b0; stb = 1'b0; cti = 3'b000;
    exp_ack = 1'b0; exp_err = 1'b0; exp_dat_chk = 1'b0;
    @(posedge clk); #1;
    exp_on = 1'b0;
  endtask

  // Single classic access on u1; returns cycles from the stb cycle to termination.
  task automatic u1_access(input logic [31:0] a, input logic w, input logic [31:0] d,
                           output int lat, output logic [31:0] rd, output logic e);
    @(posedge clk); #1;
    adr = a; we = w; wdat = d; sel = 4'hF; cti = 3'b000; bte = 2'b00;
    cyc2 = 1'b1; stb2 = 1'b1; lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (ack1 || err1) break;
    end
    check("u1_terminated", 32'(ack1 | err1), 32'd1);
    rd = dat1; e = err1;
    @(posedge clk); #1;
    check("u1_term_gap", {30'd0, ack1, err1}, 32'd0);
    cyc2 = 1'b0; stb2 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        e;
    int unsigned c0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(ack0), 32'd0);
    check("rst_err", 32'(err0), 32'd0);
    check("rst_dat", dat0, 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_cnt", 32'(cnt0), 32'd0);
    check("rst_busy_u1", 32'(busy1), 32'd0);
    rst_n = 1'b1;

    xfer(32'h10, 1'b1, 1, 3'b000, 2'b00, 4'hF, 32'hDEADBEEF, 0);
    rd_cap.delete();
    xfer(32'h10, 1'b0, 1, 3'b000, 2'b00, 4'hF, 0, 0);
    check("classic_rd_len", rd_cap.size(), 1);
    check("classic_rd", rd_cap[0], 32'hDEADBEEF);
    check("classic_cnt", 32'(cnt0), 32'd2);

    xfer(32'h20, 1'b1, 1, 3'b000, 2'b00, 4'hF, 32'hFFFFFFFF, 0);
    xfer(32'h20, 1'b1, 1, 3'b000, 2'b00, 4'b0101, 32'h11223344, 0);
    rd_cap.delete();
    xfer(32'h20, 1'b0, 1, 3'b000, 2'b00, 4'hF, 0, 0);
    check("lanes_rd", rd_cap[0], 32'hFF22FF44);

    c0 = cnt0;
    xfer(32'h0, 1'b1, 4, 3'b010, 2'b00, 4'hF, 32'd1, 32'd1);
    check("lin_wr_acks", 32'(cnt0 - c0[15:0]), 32'd4);
    rd_cap.delete();
    xfer(32'h0, 1'b0, 4, 3'b010, 2'b00, 4'hF, 0, 0);
    check("lin_rd_len", rd_cap.size(), 4);
    for (int i = 0; i < 4; i++) check("lin_rd", rd_cap[i], 32'(i + 1));

    rd_cap.delete();
    xfer(32'h8, 1'b0, 4, 3'b010, 2'b01, 4'hF, 0, 0);
    check("wrap4_len", rd_cap.size(), 4);
    check("wrap4_b0", rd_cap[0], 32'd3);
    check("wrap4_b1", rd_cap[1], 32'd4);
    check("wrap4_b2", rd_cap[2], 32'd1);
    check("wrap4_b3", rd_cap[3], 32'd2);

    rd_cap.delete();
    xfer(32'h10, 1'b0, 3, 3'b001, 2'b00, 4'hF, 0, 0);
    check("const_rd_b2", rd_cap[2], 32'hDEADBEEF);

    xfer(32'h400, 1'b1, 1, 3'b000, 2'b00, 4'hF, 32'hBAD0BAD0, 0);
    rd_cap.delete();
    xfer(32'h0, 1'b0, 1, 3'b000, 2'b00, 4'hF, 0, 0);
    check("err_no_alias", rd_cap[0], 32'd1);

    xfer(32'h34, 1'b1, 8, 3'b010, 2'b10, 4'hF, 32'hA0, 32'd1);
    rd_cap.delete();
    xfer(32'h20, 1'b0, 8, 3'b010, 2'b00, 4'hF, 0, 0);
    check("wrap8_idx8", rd_cap[0], 32'hA3);
    check("wrap8_idx13", rd_cap[5], 32'hA0);

    xfer(32'h3F8, 1'b1, 2, 3'b010, 2'b00, 4'hF, 32'h77000000, 32'd1);
    xfer(32'h3F8, 1'b0, 4, 3'b010, 2'b00, 4'hF, 0, 0);

    u1_access(32'h24, 1'b1, 32'hCAFEF00D, lat, rd, e);
    check("ws_wr_latency", 32'(lat), 32'd4);
    check("ws_wr_err", 32'(e), 32'd0);
    u1_access(32'h24, 1'b0, 32'h0, lat, rd, e);
    check("ws_rd_latency", 32'(lat), 32'd4);
    check("ws_rd_data", rd, 32'hCAFEF00D);
    u1_access(32'h400, 1'b0, 32'h0, lat, rd, e);
    check("ws_err_latency", 32'(lat), 32'd4);
    check("ws_err_flag", 32'(e), 32'd1);
    check("ws_err_data", rd, 32'd0);
    @(posedge clk); #1;
    adr = 32'h24; we = 1'b1; wdat = 32'h0; cyc2 = 1'b1; stb2 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("ws_abort_busy", 32'(busy1), 32'd1);
    cyc2 = 1'b0; stb2 = 1'b0;
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
        @(posedge clk); #1;
        if (ack1 || err1) seen = 1'b1;
      end
      check("ws_abort_noterm", 32'(seen), 32'd0);
    end
    check("ws_abort_idle", 32'(busy1), 32'd0);
    u1_access(32'h24, 1'b0, 32'h0, lat, rd, e);
    check("ws_abort_nowrite", rd, 32'hCAFEF00D);
    check("ws_cnt", 32'(cnt1), 32'd3);

    xfer(32'h40, 1'b1, 8, 3'b010, 2'b00, 4'hF, 32'h5000, 32'd1);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; bte = 2'b00; cti = 3'b010;
    adr = 32'h40; wdat = 32'h6000;
    @(posedge clk); #1;
    for (int k = 1; k <= 2; k++) begin
      @(posedge clk); #1;
      adr = 32'h40 + 4 * k; wdat = 32'h6000 + k;
    end
    model_mem[16] = 32'h6000;
    model_mem[17] = 32'h6001;
    check("rstmid_pre_ack", 32'(ack0), 32'd1);
    check("rstmid_pre_cnt", 32'(cnt0), 32'(model_cnt[15:0] + 16'd2));
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_ack", 32'(ack0), 32'd0);
    check("rstmid_busy", 32'(busy0), 32'd0);
    check("rstmid_cnt", 32'(cnt0), 32'd0);
    model_cnt = 0;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; cti = 3'b000;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rd_cap.delete();
    xfer(32'h40, 1'b0, 8, 3'b010, 2'b00, 4'hF, 0, 0);
    check("rstmid_b1", rd_cap[1], 32'h6001);
    check("rstmid_b2", rd_cap[2], 32'h5002);
    check("rstmid_b7", rd_cap[7], 32'h5007);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
